dmem_responder: RTL and testbench

Data-memory responder for the single-cycle RV64 core: the memory end of the core's `addr`/`wr_en`/`wdata`/`wmask`/`rdata` data port. It holds a doubleword-organised RAM with byte-masked, offset-aligned stores and combinational reads. It also provides a small MMIO window with:
- a free-running cycle counter
- a compare timer with sticky interrupt pending
- a TOHOST register that halts the system for the testbench

It sits beside the core in the top level, in place of a behavioural memory model.

---
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-masked doubleword RAM plus MMIO cycle counter, compare timer and TOHOST.
// Reads are combinational (zero latency); writes commit at the clock edge; no backpressure.
module dmem_responder #(
  parameter int          DEPTH_DW  = 512,
  parameter logic [31:0] MMIO_BASE = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [63:0] wdata,
  input  logic [7:0]  wmask,
  output logic [63:0] rdata,
  output logic        timer_irq,
  output logic        halt,
  output logic [63:0] tohost
);

  localparam int AW = $clog2(DEPTH_DW);

  localparam logic [2:0] REG_CYCLE   = 3'd0;
  localparam logic [2:0] REG_TIMECMP = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_TOHOST  = 3'd3;

  logic [63:0]   mem [DEPTH_DW];

  logic [AW-1:0] idx;
  logic [2:0]    off;
  logic [2:0]    reg_sel;
  logic          is_mmio;

  logic [63:0]   cycle;
  logic [63:0]   timecmp;
  logic          pending;

  logic [7:0]    eff_mask;
  logic [63:0]   eff_data;
  logic          ram_we;
  logic          mmio_we;
  logic          timecmp_we;
  logic          tohost_we;
  logic          status_clr;
  logic          cmp_hit;
  logic [63:0]   tohost_nxt;
  logic [63:0]   mmio_rd;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old,
                                              input logic [63:0] d,
                                              input logic [7:0]  m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) begin
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  assign idx     = addr[3 +: AW];
  assign off     = addr[2:0];
  assign reg_sel = addr[5:3];
  assign is_mmio = (addr[31:6] == MMIO_BASE[31:6]);

  // Lanes shifted past byte 7 fall off the top; stores never straddle doublewords.
  assign eff_mask = wmask << off;
  assign eff_data = wdata << {off, 3'b000};

  assign ram_we     = wr_en && !halt && !is_mmio;
  assign mmio_we    = wr_en && !halt && is_mmio && (off == 3'd0);
  assign timecmp_we = mmio_we && (reg_sel == REG_TIMECMP);
  assign tohost_we  = mmio_we && (reg_sel == REG_TOHOST);
  assign status_clr = mmio_we && (reg_sel == REG_STATUS) && wmask[0] && wdata[0];
  assign cmp_hit    = (cycle >= timecmp);
  assign tohost_nxt = merge_bytes(tohost, wdata, wmask);

  always_comb begin
    mmio_rd = '0;
    if (off == 3'd0) begin
      case (reg_sel)
        REG_CYCLE:   mmio_rd = cycle;
        REG_TIMECMP: mmio_rd = timecmp;
        REG_STATUS:  mmio_rd = {63'd0, pending};
        REG_TOHOST:  mmio_rd = tohost;
        default:     mmio_rd = '0;
      endcase
    end
  end

  assign rdata     = is_mmio ? mmio_rd : (mem[idx] >> {off, 3'b000});
  assign timer_irq = pending;

  // RAM contents deliberately survive reset; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      for (int b = 0; b < 8; b++) begin
        if (eff_mask[b]) mem[idx][8*b +: 8] <= eff_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle   <= '0;
      timecmp <= '1;
      pending <= 1'b0;
      tohost  <= '0;
      halt    <= 1'b0;
    end else begin
      if (!halt) cycle <= cycle + 64'd1;
      if (timecmp_we) timecmp <= merge_bytes(timecmp, wdata, wmask);
      if (tohost_we) begin
        tohost <= tohost_nxt;
        if (tohost_nxt != '0) halt <= 1'b1;
      end
      // Set has priority over a same-cycle W1C.
      pending <= cmp_hit | (pending & ~status_clr);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: RAM stores/loads, MMIO timer, halt and async reset.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wr_en;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic [63:0] rdata;
  logic        timer_irq;
  logic        halt;
  logic [63:0] tohost;

  int          nerr = 0;
  int          nchk = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [63:0] cyc_m;
  logic        halt_m;

  dmem_responder #(.DEPTH_DW(512), .MMIO_BASE(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .wmask     (wmask),
    .rdata     (rdata),
    .timer_irq (timer_irq),
    .halt      (halt),
    .tohost    (tohost)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: counts edges with reset low while not halted.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc_m <= '0;
    else if (!halt_m) cyc_m <= cyc_m + 64'd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_chk(input logic [63:0] got);
    string       t;
    logic [63:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    chk(t, got, e);
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic [63:0] d, input logic [7:0] m);
    addr  = a;
    wr_en = we;
    wdata = d;
    wmask = m;
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [63:0] exp);
    drive(a, 1'b0, 64'd0, 8'd0);
    push(tag, exp);
    @(negedge clk);
    pop_chk(rdata);
    cyc_end();
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    drive(a, 1'b1, d, m);
    cyc_end();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] irq_exp;
    rst    = 1'b1;
    halt_m = 1'b0;
    drive(32'd0, 1'b0, 64'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_irq", timer_irq, 64'd0);
    chk("rst_halt", halt, 64'd0);
    chk("rst_tohost", tohost, 64'd0);
    rd("rst_cycle", MB, 64'd0);
    rd("rst_timecmp", MB + 32'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    rst = 1'b0;

    // Counter and timer: TIMECMP=20 written in cycle 2; irq visible from CYCLE=21
    for (int n = 0; n < 30; n++) begin
      if (n == 2) begin
        drive(MB + 32'd8, 1'b1, 64'd20, 8'hFF);
        @(negedge clk);
      end else begin
        drive(MB, 1'b0, 64'd0, 8'd0);
        push("cycle_count", cyc_m);
        @(negedge clk);
        pop_chk(rdata);
      end
      irq_exp = (cyc_m >= 64'd21) ? 64'd1 : 64'd0;
      chk("irq_rise", timer_irq, irq_exp);
      cyc_end();
    end

    wr(MB + 32'h10, 64'd1, 8'h01);
    chk("irq_w1c_hold", timer_irq, 64'd1);
    rd("status_hold", MB + 32'h10, 64'd1);
    wr(MB + 32'd8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(MB + 32'h10, 64'd1, 8'h01);
    chk("irq_fall", timer_irq, 64'd0);
    rd("status_clear", MB + 32'h10, 64'd0);

    // RAM stores and loads
    wr(32'h10, 64'h1122_3344_5566_7788, 8'hFF);
    rd("sd_read", 32'h10, 64'h1122_3344_5566_7788);
    rd("offset_read", 32'h14, 64'h0000_0000_1122_3344);
    wr(32'h13, 64'hAA, 8'h01);
    rd("sb_offset", 32'h10, 64'h1122_3344_AA66_7788);
    wr(32'h16, 64'hDEAD_BEEF, 8'h0F);
    rd("sw_truncated", 32'h10, 64'hBEEF_3344_AA66_7788);
    wr(32'h1000, 64'd5, 8'hFF);
    rd("alias", 32'h0, 64'd5);

    // Same-cycle read sees old data
    drive(32'h10, 1'b1, 64'hCAFE, 8'hFF);
    push("no_bypass", 64'hBEEF_3344_AA66_7788);
    @(negedge clk);
    pop_chk(rdata);
    cyc_end();
    rd("bypass_next", 32'h10, 64'hCAFE);

    // MMIO access rules
    rd("mmio_offset_rd", MB + 32'd1, 64'd0);
    rd("mmio_unmapped", MB + 32'h20, 64'd0);
    wr(MB + 32'h19, 64'd5, 8'hFF);
    rd("mmio_offset_wr", MB + 32'h18, 64'd0);
    chk("halt_offset_wr", halt, 64'd0);

    // Compare of zero raises irq; store RAM word before halting
    wr(MB + 32'd8, 64'd0, 8'hFF);
    wr(32'h20, 64'h0123_4567_89AB_CDEF, 8'hFF);
    chk("irq_cmp0", timer_irq, 64'd1);

    // Halt
    wr(MB + 32'h18, 64'd1, 8'hFF);
    halt_m = 1'b1;
    chk("halt_set", halt, 64'd1);
    chk("tohost_set", tohost, 64'd1);
    rd("cycle_frozen", MB, cyc_m);
    rd("cycle_frozen2", MB, cyc_m);
    wr(32'h20, 64'hFFFF, 8'hFF);
    rd("halt_ram", 32'h20, 64'h0123_4567_89AB_CDEF);
    wr(MB + 32'h18, 64'd0, 8'hFF);
    chk("halt_sticky", halt, 64'd1);
    chk("tohost_sticky", tohost, 64'd1);

    // Asynchronous reset pulse between edges
    drive(MB, 1'b0, 64'd0, 8'd0);
    @(negedge clk);
    #1;
    rst    = 1'b1;
    halt_m = 1'b0;
    push("arst_cycle", 64'd0);
    #1;
    pop_chk(rdata);
    chk("arst_halt", halt, 64'd0);
    chk("arst_irq", timer_irq, 64'd0);
    chk("arst_tohost", tohost, 64'd0);
    #1;
    rst = 1'b0;
    cyc_end();
    rd("ram_kept", 32'h10, 64'hCAFE);
    rd("ram_kept2", 32'h20, 64'h0123_4567_89AB_CDEF);
    rd("cycle_restart", MB, cyc_m);
    chk("irq_after_rst", timer_irq, 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
